scsi_local_bus_arbiter: RTL
===========================

// Module: scsi_local_bus_arbiter
// PURPOSE
//  Owns the SIOP local bus. Arbitrates it between Zorro slave accesses to the SCSI region and
//  53C710 DMA bus-master requests (BR/BG/BGACK). Sequences SIOP chip select, waits for the chip's
//  slave ack and returns scsi_dtack to the Zorro slave logic. Sits between address decode and the SIOP pins.
// PARAMETERS
//  SETUP_CYCLES   1    CLK cycles from slave grant to SIOP_CS_n assertion (address setup), 0..15
//  TIMEOUT_CYCLES 255  max CLK cycles in SLV_WAIT before watchdog fires (only with SCSI_ARB_TIMEOUT_EN)
//  CNT_W          8    width of the shared setup/timeout counter; must hold both values above
// PORTS
//  CLK            in   1  system clock, all logic on rising edge
//  RESET_n        in   1  asynchronous active-low reset
//  FCS_n          in   1  Zorro full cycle strobe, active low
//  scsi_region    in   1  decoded: slave_cycle && configured && address in SCSI window
//  READ           in   1  Zorro direction, 1 = host read
//  SIOP_BR_n      in   1  53C710 bus request, active low
//  SIOP_BGACK_n   in   1  53C710 bus grant acknowledge, active low
//  SIOP_SLACK_n   in   1  53C710 slave acknowledge, active low
//  SIOP_BG_n      out  1  bus grant to 53C710, active low
//  SIOP_CS_n      out  1  53C710 chip select, active low
//  SIOP_RW        out  1  registered copy of READ during slave cycle
//  scsi_dtack     out  1  slave cycle complete, to Zorro DTACK logic, active high
//  master_active  out  1  1 while the SIOP owns the local bus
//  bus_error      out  1  sticky watchdog flag (SCSI_ARB_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  Reset: state IDLE; SIOP_BG_n=1, SIOP_CS_n=1, SIOP_RW=1, scsi_dtack=0, master_active=0,
//   bus_error=0, counter=0, pend_master=0. Reset mid-cycle aborts instantly to these values.
//  States: IDLE, SLV_SETUP, SLV_WAIT, SLV_ACK, MST_GRANT, MST_OWN.
//  slave_req = !FCS_n && scsi_region; master_req = !SIOP_BR_n.
//  IDLE: if slave_req && !pend_master -> SLV_SETUP (latch SIOP_RW<=READ, counter<=0);
//   else if master_req -> MST_GRANT; else stay. Simultaneous slave_req and master_req with
//   pend_master=0: slave wins, pend_master<=1.
//  SLV_SETUP: counter++ each cycle; when counter==SETUP_CYCLES -> SLV_WAIT, SIOP_CS_n<=0, counter<=0.
//   SETUP_CYCLES=0: CS asserted on cycle after IDLE exit.
//  SLV_WAIT: CS held low; on !SIOP_SLACK_n -> SLV_ACK, scsi_dtack<=1. Latency FCS_n fall to
//   scsi_dtack = SETUP_CYCLES+2 cycles plus SLACK wait.
//  SLV_ACK: CS and dtack held until FCS_n=1, then -> IDLE with CS_n<=1, dtack<=0 same edge.
//  FCS_n deasserting before SLV_ACK (host abort): -> IDLE next edge, CS_n<=1, no dtack.
//  MST_GRANT: SIOP_BG_n=0; on !SIOP_BGACK_n -> MST_OWN, BG_n<=1, master_active<=1, pend_master<=0.
//   If SIOP_BR_n returns high before BGACK: -> IDLE, BG_n<=1, pend_master<=0.
//  MST_OWN: stay while !SIOP_BGACK_n; on BGACK_n=1 -> IDLE, master_active<=0.
//  Slave requests during MST_GRANT/MST_OWN are held (no CS, no dtack) until IDLE.
//  Fairness: pend_master=1 blocks new slave grants in IDLE; master served next, then slave.
//  SIOP_CS_n and SIOP_BG_n never both low; master_active and SIOP_CS_n=0 mutually exclusive.
//  Counter saturates at 2^CNT_W-1; never wraps.
// CONFIGURATION
//  SCSI_ARB_TIMEOUT_EN defined: in SLV_WAIT counter increments; at counter==TIMEOUT_CYCLES
//   -> SLV_ACK with scsi_dtack<=1, SIOP_CS_n<=1, bus_error<=1 (sticky until RESET_n).
//   Host is released with undefined data; SLACK arriving same edge as timeout counts as normal ack
//   (bus_error not set).
//  Not defined: SLV_WAIT waits for SLACK indefinitely; bus_error constant 0; no timeout logic.
// TESTING
//  1 Host read, SETUP_CYCLES=1, SLACK 3 cycles after CS -> CS_n low 2 cycles after FCS_n fall,
//    scsi_dtack 1 cycle after SLACK, SIOP_RW=1, CS_n/dtack drop 1 cycle after FCS_n rise.
//  2 BR_n low in IDLE, BGACK_n 2 cycles after BG_n -> BG_n low 1 cycle, master_active=1 until
//    BGACK_n high, then IDLE; CS_n stays 1 throughout.
//  3 FCS_n and BR_n fall same edge -> slave completes first, next FCS_n held in IDLE while
//    master granted; slave served after BGACK_n release.
//  4 FCS_n rises in SLV_WAIT before SLACK -> IDLE next edge, scsi_dtack never 1.
//  5 SCSI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no SLACK -> scsi_dtack=1 and bus_error=1 at 16th
//    SLV_WAIT cycle; without macro dtack stays 0 for 1000 cycles.
//  6 RESET_n low during MST_OWN and during SLV_ACK -> all outputs at reset values immediately.

Source files
------------

// File: rtl/scsi_local_bus_arbiter.sv
// scsi_local_bus_arbiter
// Owns the 53C710 (SIOP) local bus. It arbitrates between Zorro slave accesses to the SCSI
// window and SIOP DMA bus-master requests (BR/BG/BGACK). For slave accesses it sequences
// SIOP_CS_n and returns scsi_dtack once the chip acknowledges.
// Optional feature: define SCSI_ARB_TIMEOUT_EN to add a slave-wait watchdog. The watchdog
// releases the host after TIMEOUT_CYCLES and sets the sticky bus_error flag.
module scsi_local_bus_arbiter #(
  parameter int SETUP_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic CLK,
  input  logic RESET_n,
  input  logic FCS_n,
  input  logic scsi_region,
  input  logic READ,
  input  logic SIOP_BR_n,
  input  logic SIOP_BGACK_n,
  input  logic SIOP_SLACK_n,
  output logic SIOP_BG_n,
  output logic SIOP_CS_n,
  output logic SIOP_RW,
  output logic scsi_dtack,
  output logic master_active,
  output logic bus_error
);

  typedef enum logic [2:0] {
    IDLE, SLV_SETUP, SLV_WAIT, SLV_ACK, MST_GRANT, MST_OWN
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_V = CNT_W'(SETUP_CYCLES);

  // Catch parameter sets that the shared counter cannot represent.
  if (SETUP_CYCLES < 0 || SETUP_CYCLES > 15 || SETUP_CYCLES > (2**CNT_W - 1)) begin : g_bad_setup
    $error("SETUP_CYCLES out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2**CNT_W - 1)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES does not fit CNT_W");
  end

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pend_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             slave_req;
  logic             master_req;

  assign slave_req  = !FCS_n && scsi_region;
  assign master_req = !SIOP_BR_n;
  // Saturating increment: the counter sticks at all-ones rather than wrapping.
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef SCSI_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT_CYCLES);
  logic berr_q;
  assign bus_error = berr_q;
`else
  assign bus_error = 1'b0;
`endif

  // Arbitration FSM. All pin-facing outputs are registered here.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      SIOP_BG_n     <= 1'b1;
      SIOP_CS_n     <= 1'b1;
      SIOP_RW       <= 1'b1;
      scsi_dtack    <= 1'b0;
      master_active <= 1'b0;
`ifdef SCSI_ARB_TIMEOUT_EN
      berr_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (slave_req && !pend_q) begin
            state_q <= SLV_SETUP;
            SIOP_RW <= READ;
            cnt_q   <= '0;
            // The master that lost the tie is served before the next slave cycle.
            if (master_req) pend_q <= 1'b1;
          end else if (master_req) begin
            state_q   <= MST_GRANT;
            SIOP_BG_n <= 1'b0;
          end else begin
            // A pending master that dropped BR must not lock slaves out forever.
            pend_q <= 1'b0;
          end
        end
        SLV_SETUP: begin
          if (FCS_n) begin
            state_q <= IDLE;
          end else if (cnt_q == SETUP_V) begin
            state_q   <= SLV_WAIT;
            SIOP_CS_n <= 1'b0;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        SLV_WAIT: begin
          if (FCS_n) begin
            state_q   <= IDLE;
            SIOP_CS_n <= 1'b1;
          end else if (!SIOP_SLACK_n) begin
            state_q    <= SLV_ACK;
            scsi_dtack <= 1'b1;
`ifdef SCSI_ARB_TIMEOUT_EN
          end else if (cnt_q == TO_V) begin
            state_q    <= SLV_ACK;
            scsi_dtack <= 1'b1;
            SIOP_CS_n  <= 1'b1;
            berr_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_inc;
`endif
          end
        end
        SLV_ACK: begin
          if (FCS_n) begin
            state_q    <= IDLE;
            SIOP_CS_n  <= 1'b1;
            scsi_dtack <= 1'b0;
          end
        end
        MST_GRANT: begin
          if (!SIOP_BGACK_n) begin
            state_q       <= MST_OWN;
            SIOP_BG_n     <= 1'b1;
            master_active <= 1'b1;
            pend_q        <= 1'b0;
          end else if (!master_req) begin
            state_q   <= IDLE;
            SIOP_BG_n <= 1'b1;
            pend_q    <= 1'b0;
          end
        end
        MST_OWN: begin
          if (SIOP_BGACK_n) begin
            state_q       <= IDLE;
            master_active <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
